// File: rtl/ram_rd_pkg.sv
// Shared types and width helpers for the RAM burst reader.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width that can hold every value from 0 up to and including depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CREDIT_W = credit_width(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/ram_rd_fifo.sv
// Synchronous output FIFO for the RAM burst reader; stores {last,data}
// entries and exposes an occupancy count for the credit check.
module ram_rd_fifo
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           push_last,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          head_data,
  output logic                           head_last,
  output logic                           empty,
  output logic [credit_width(DEPTH)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = credit_width(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                full;
  logic                do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;

  // The head is forced to zero while empty so idle outputs read as zero.
  always_comb begin
    head_data = '0;
    head_last = 1'b0;
    if (!empty) begin
      head_data = mem[rd_ptr][DATA_WIDTH-1:0];
      head_last = mem[rd_ptr][DATA_WIDTH];
    end
  end

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_last, push_data};
    end
  end

  // Pointer and occupancy tracking; a push into a full FIFO is only legal
  // when a pop frees the slot in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full && !do_pop));
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for the on-chip RAM: takes a (base, length) command,
// issues one read per cycle within the output FIFO's credit, and streams
// the returned words out on a valid/ready interface.
// Optional feature macro: RAM_RD_STRIDE_EN adds a per-command address stride
// (cmd_stride); without it the stride is fixed at 1.
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len_m1,
`ifdef RAM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  output logic                  mem_read_req,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = credit_width(FIFO_DEPTH);

  if (RD_LATENCY < 1 || RD_LATENCY > 4 || FIFO_DEPTH < RD_LATENCY + 1 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("ram_burst_reader: illegal RD_LATENCY/FIFO_DEPTH combination");
  end

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0] stride;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_last;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           outstanding;
  logic                  credit_ok;
  logic                  issue;
  logic                  last_issue;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;

`ifdef RAM_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;
  assign stride = stride_q;
`else
  assign stride = ADDR_WIDTH'(1);
`endif

  // Every word either still travelling through the RAM or sitting in the
  // FIFO holds one credit; a read is only issued while a slot is guaranteed.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CW'(pipe_valid[i]);
    end
    outstanding = {1'b0, in_flight} + {1'b0, fifo_count};
    credit_ok   = (outstanding < (CW + 1)'(FIFO_DEPTH));
  end

  assign issue         = (state == ISSUE) && credit_ok;
  assign last_issue    = issue && (remaining == '0);
  assign mem_read_req  = issue;
  assign mem_read_addr = addr;
  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign push          = pipe_valid[RD_LATENCY-1];
  assign m_valid       = !fifo_empty;
  assign pop           = m_valid && m_ready;
  assign done          = pop && m_last;

  // Burst control: latch the command, walk the address per issued read and
  // hold in DRAIN until the final word has been handed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
`ifdef RAM_RD_STRIDE_EN
      stride_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_base_addr;
            remaining <= cmd_len_m1;
`ifdef RAM_RD_STRIDE_EN
            stride_q  <= cmd_stride;
`endif
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr <= addr + stride;
            if (remaining == '0) begin
              state <= DRAIN;
            end else begin
              remaining <= remaining - ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latency pipe mirrors the RAM's read delay so returning data can be
  // tagged valid/last; clearing it on reset discards in-flight returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_last[0]  <= last_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
    end
  end

  ram_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(mem_read_data),
    .push_last(pipe_last[RD_LATENCY-1]),
    .pop      (pop),
    .head_data(m_data),
    .head_last(m_last),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a latency-configurable RAM model
// preloaded with mem[i]=i and a queue-based scoreboard of expected words.
module tb_ram_burst_reader;

  localparam int DW    = 10;
  localparam int AW    = 12;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [AW-1:0] cmd_len_m1 = '0;
  logic [AW-1:0] cmd_stride = AW'(1);
  logic          mem_read_req;
  logic [AW-1:0] mem_read_addr;
  logic [DW-1:0] mem_read_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  word_t         exp_q[$];
  logic [DW-1:0] ram_mem [4096];
  logic [DW-1:0] ram_pipe [LAT];

  int            to_issue = 0;
  int            outstanding = 0;
  int            done_count = 0;
  int            accepted = 0;
  logic [AW-1:0] next_addr = '0;
  logic [AW-1:0] mon_stride = '0;

  always #5 clk = ~clk;

  ram_burst_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RD_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_len_m1   (cmd_len_m1),
`ifdef RAM_RD_STRIDE_EN
    .cmd_stride   (cmd_stride),
`endif
    .mem_read_req (mem_read_req),
    .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = DW'(i);
    for (int i = 0; i < LAT; i++) ram_pipe[i] = '0;
  end

  // RAM model: read data appears LAT cycles after the request edge.
  always @(posedge clk) begin
    ram_pipe[0] <= mem_read_req ? ram_mem[mem_read_addr] : '0;
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign mem_read_data = ram_pipe[LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW-1:0] effStride(input logic [AW-1:0] s);
`ifdef RAM_RD_STRIDE_EN
    return s;
`else
    return AW'(1);
`endif
  endfunction

  // Pushes the expected words for a burst, then presents the command until accepted.
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic [AW-1:0] stride);
    word_t         w;
    logic [AW-1:0] a;
    int            n;
    a = base;
    for (int i = 0; i <= int'(len); i++) begin
      w.last = (i == int'(len));
      w.data = ram_mem[a];
      exp_q.push_back(w);
      a = a + effStride(stride);
    end
    cmd_base_addr = base;
    cmd_len_m1    = len;
    cmd_stride    = stride;
    cmd_valid     = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
    end
    checkOutput("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output logic done_before);
    done_before = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy) break;
      done_before = done;
    end
    checkOutput("idle", busy, 0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_req", mem_read_req, 0);
    checkOutput("rst_addr", mem_read_addr, 0);
    checkOutput("rst_valid", m_valid, 0);
    checkOutput("rst_data", m_data, 0);
    checkOutput("rst_last", m_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
  endtask

  // Monitor: checks the credit-limited issue pattern, read addresses and
  // the output stream against the scoreboard on every falling edge.
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      to_issue    = 0;
      outstanding = 0;
      exp_q.delete();
    end else begin
      checkOutput("req_credit", mem_read_req, (to_issue > 0 && outstanding < DEPTH));
      if (mem_read_req) begin
        checkOutput("rd_addr", mem_read_addr, next_addr);
        next_addr = next_addr + mon_stride;
        to_issue--;
        outstanding++;
      end
      if (m_valid) checkOutput("valid_has_exp", exp_q.size() > 0, 1);
      if (m_valid && m_ready && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        checkOutput("m_data", m_data, w.data);
        checkOutput("m_last", m_last, w.last);
        checkOutput("done", done, w.last);
        if (done) done_count++;
        outstanding--;
        accepted++;
      end else begin
        checkOutput("done_quiet", done, 0);
      end
      if (cmd_valid && cmd_ready) begin
        to_issue   = int'(cmd_len_m1) + 1;
        next_addr  = cmd_base_addr;
        mon_stride = effStride(cmd_stride);
      end
    end
  end

  initial begin
    int   cyc;
    int   run;
    int   acc0;
    logic done_before;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("cmd_ready_init", cmd_ready, 1);
    @(posedge clk);
    #1;

    // 1: eight words back-to-back, first word after LAT+1 edges
    applyStimulus(12'h010, 12'd7, 12'd1);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (!m_valid && cyc < 20);
    checkOutput("first_latency", cyc, LAT + 1);
    run = 0;
    repeat (7) begin
      @(negedge clk);
      if (m_valid) run++;
    end
    checkOutput("back_to_back", run, 7);
    waitIdle(50, done_before);
    checkOutput("done_count1", done_count, 1);
    @(posedge clk);
    #1;

    // 2: address wrap at the top of the RAM
    applyStimulus(12'hFFE, 12'd3, 12'd1);
    waitIdle(50, done_before);
    checkOutput("done_count2", done_count, 2);
    @(posedge clk);
    #1;

    // 3: backpressure, then toggling ready
    m_ready = 1'b0;
    applyStimulus(12'h200, 12'd15, 12'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("stall_req", mem_read_req, 0);
    checkOutput("stall_valid", m_valid, 1);
    for (int k = 0; k < 200 && busy; k++) begin
      @(posedge clk);
      #1;
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    waitIdle(50, done_before);
    checkOutput("done_count3", done_count, 3);
    @(posedge clk);
    #1;

    // 4: single-word burst, ready again the cycle after done
    applyStimulus(12'h055, 12'd0, 12'd1);
    waitIdle(50, done_before);
    checkOutput("done_then_ready", {done_before, cmd_ready}, 2'b11);
    checkOutput("done_count4", done_count, 4);
    @(posedge clk);
    #1;

    // 5: reset mid-burst, then a clean burst
    acc0 = accepted;
    applyStimulus(12'h300, 12'd15, 12'd1);
    for (int k = 0; k < 100 && (accepted - acc0) < 3; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("words_before_rst", accepted - acc0, 3);
    rst = 1'b1;
    #1;
    checkResetOutputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(12'h100, 12'd3, 12'd1);
    waitIdle(50, done_before);
    checkOutput("done_count5", done_count, 5);
    @(posedge clk);
    #1;

`ifdef RAM_RD_STRIDE_EN
    // 6: strided burst
    applyStimulus(12'h000, 12'd3, 12'h004);
    waitIdle(50, done_before);
    checkOutput("done_count6", done_count, 6);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
